master_slave_sequencer: RTL and testbench

//  Shares one blocking slave port (request data out with sync, response data in with sync) among N_REQ master requesters.

---
 rtl/master_slave_sequencer_pkg.sv | 10 +
 rtl/master_slave_sequencer_rr_pick.sv | 28 ++
 rtl/master_slave_sequencer.sv | 99 +++++++++
 tb/tb_master_slave_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/master_slave_sequencer_pkg.sv
// Shared types and default sizing for the master/slave sequencer.
package master_slave_sequencer_types;

   typedef enum logic {SECTION_IDLE, SECTION_WAIT} sections;

   localparam int N_REQ_DEF   = 4;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/master_slave_sequencer_rr_pick.sv
// Round-robin picker: first asserted request after the last winner, wrapping mod N_REQ.
module rr_pick
   import master_slave_sequencer_types::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int LW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [LW-1:0]    last,
   output logic             any,
   output logic [LW-1:0]    idx
);

   // Scan from the farthest offset down so the nearest candidate is assigned last and wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         int c;
         c = (int'(last) + k) % N_REQ;
         if (req[c]) begin
            any = 1'b1;
            idx = LW'(c);
         end
      end
   end

endmodule

// File: rtl/master_slave_sequencer.sv
// Arbitrates N_REQ requesters onto one blocking slave port, one transaction at a time,
// routing the slave response or a timeout error back to the winner.
module master_slave_sequencer
   import master_slave_sequencer_types::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ack,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic [DATA_W-1:0]       slv_out,
   output logic                    slv_out_sync,
   input  logic [DATA_W-1:0]       slv_in,
   input  logic                    slv_in_sync,
   output logic                    busy,
   output logic                    stray_sync
);

   localparam int LW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT);

   sections         state;
   logic [LW-1:0]   grant;
   logic [LW-1:0]   last_grant;
   logic [TW-1:0]   timer;
   logic            pick_any;
   logic [LW-1:0]   pick_idx;

   rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SECTION_IDLE;
         grant        <= '0;
         last_grant   <= LW'(N_REQ - 1);
         timer        <= '0;
         req_ack      <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         slv_out      <= '0;
         slv_out_sync <= 1'b0;
         busy         <= 1'b0;
         stray_sync   <= 1'b0;
      end else begin
         req_ack      <= '0;
         rsp_valid    <= '0;
         rsp_err      <= 1'b0;
         slv_out_sync <= 1'b0;
         case (state)
            SECTION_IDLE: begin
               // A slave sync with nothing outstanding is dropped but remembered.
               if (slv_in_sync) stray_sync <= 1'b1;
               if (pick_any) begin
                  grant        <= pick_idx;
                  slv_out      <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                  slv_out_sync <= 1'b1;
                  req_ack      <= N_REQ'(1) << pick_idx;
                  timer        <= '0;
                  busy         <= 1'b1;
                  state        <= SECTION_WAIT;
               end
            end
            SECTION_WAIT: begin
               if (slv_in_sync) begin
                  rsp_data   <= slv_in;
                  rsp_valid  <= N_REQ'(1) << grant;
                  last_grant <= grant;
                  busy       <= 1'b0;
                  state      <= SECTION_IDLE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  rsp_data   <= '0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= N_REQ'(1) << grant;
                  last_grant <= grant;
                  busy       <= 1'b0;
                  state      <= SECTION_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= SECTION_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_master_slave_sequencer.sv
// Scoreboard bench for master_slave_sequencer: directed requests, queued expectations, decoupled monitor.
module tb_master_slave_sequencer;

   localparam int N_REQ   = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ack;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;
   logic [DATA_W-1:0]       slv_out;
   logic                    slv_out_sync;
   logic [DATA_W-1:0]       slv_in;
   logic                    slv_in_sync;
   logic                    busy;
   logic                    stray_sync;

   master_slave_sequencer #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ack      (req_ack),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .slv_out      (slv_out),
      .slv_out_sync (slv_out_sync),
      .slv_in       (slv_in),
      .slv_in_sync  (slv_in_sync),
      .busy         (busy),
      .stray_sync   (stray_sync)
   );

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t ack_q[$];
   exp_t rsp_q[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every ack and every response must match the head of its queue.
   always @(negedge clk) begin
      if (req_ack != '0) begin
         if (ack_q.size() == 0) check("ack_unexpected", 64'(req_ack), 64'h0);
         else begin
            exp_t e;
            e = ack_q.pop_front();
            check("ack_onehot", 64'(req_ack), 64'(4'b0001 << e.idx));
            check("ack_slv_out", 64'(slv_out), 64'(e.data));
            check("ack_slv_sync", 64'(slv_out_sync), 64'h1);
         end
      end
      if (rsp_valid != '0) begin
         if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'h0);
         else begin
            exp_t e;
            e = rsp_q.pop_front();
            check("rsp_onehot", 64'(rsp_valid), 64'(4'b0001 << e.idx));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   task automatic push(input int idx, input logic [31:0] req_d, input logic [31:0] rsp_d,
                       input logic err);
      exp_t a;
      exp_t r;
      a.idx = idx; a.data = req_d; a.err = 1'b0;
      r.idx = idx; r.data = rsp_d; r.err = err;
      ack_q.push_back(a);
      rsp_q.push_back(r);
   endtask

   task automatic set_req(input int idx, input logic [31:0] d);
      req_data[idx*DATA_W +: DATA_W] = d;
      req_valid[idx] = 1'b1;
   endtask

   // Waits for an ack, retires the acked requester and returns the cycle it was seen.
   task automatic wait_ack(input string name, output int at);
      at = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ack != '0) begin
            at = cyc;
            req_valid = req_valid & ~req_ack;
            break;
         end
      end
      if (at < 0) check(name, 64'h0, 64'h1);
   endtask

   task automatic wait_rsp(input string name, output int at);
      at = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         slv_in_sync = 1'b0;
         if (rsp_valid != '0) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check(name, 64'h0, 64'h1);
   endtask

   task automatic slave_reply(input string name, input logic [31:0] d);
      int a;
      int r;
      wait_ack(name, a);
      slv_in = d;
      slv_in_sync = 1'b1;
      wait_rsp(name, r);
   endtask

   task automatic pulse_sync(input logic [31:0] d);
      slv_in = d;
      slv_in_sync = 1'b1;
      @(negedge clk);
      slv_in_sync = 1'b0;
   endtask

   initial begin
      int a;
      int r;
      int t0;
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      slv_in = '0;
      slv_in_sync = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ack", 64'(req_ack), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_slv_sync", 64'(slv_out_sync), 64'h0);
      check("idle_stray", 64'(stray_sync), 64'h0);

      // Round-robin from reset: all four pending, each drops after its ack.
      for (int i = 0; i < 4; i++) begin
         set_req(i, 32'h100 + i);
         push(i, 32'h100 + i, 32'hB0 + i, 1'b0);
      end
      for (int i = 0; i < 4; i++) slave_reply("t2_wait", 32'hB0 + i);
      repeat (3) @(negedge clk);
      check("t2_acks_drained", 64'(ack_q.size()), 64'h0);

      // Single request, slave answers one cycle after the sync pulse.
      t0 = cyc;
      set_req(0, 32'h11);
      push(0, 32'h11, 32'hAA, 1'b0);
      wait_ack("t1_ack", a);
      slv_in = 32'hAA;
      slv_in_sync = 1'b1;
      wait_rsp("t1_rsp", r);
      check("t1_latency", 64'(r - t0), 64'd2);

      // Timeout with a silent slave.
      @(negedge clk);
      set_req(2, 32'h33);
      push(2, 32'h33, 32'h0, 1'b1);
      wait_ack("t3_ack", a);
      check("t3_busy_wait", 64'(busy), 64'h1);
      wait_rsp("t3_rsp", r);
      check("t3_latency", 64'(r - a), 64'd16);
      @(negedge clk);
      check("t3_busy_after", 64'(busy), 64'h0);

      // Slave sync lands on the same edge as the timeout: the sync wins.
      set_req(1, 32'h44);
      push(1, 32'h44, 32'h55, 1'b0);
      wait_ack("t4_ack", a);
      repeat (15) @(negedge clk);
      slv_in = 32'h55;
      slv_in_sync = 1'b1;
      @(negedge clk);
      slv_in_sync = 1'b0;
      check("t4_rsp_valid", 64'(rsp_valid), 64'h2);
      check("t4_latency", 64'(cyc - a), 64'd16);

      // Stray sync in IDLE, then a normal transaction.
      @(negedge clk);
      pulse_sync(32'hDEAD);
      check("t5_stray_set", 64'(stray_sync), 64'h1);
      repeat (3) @(negedge clk);
      check("t5_stray_hold", 64'(stray_sync), 64'h1);
      set_req(3, 32'h66);
      push(3, 32'h66, 32'h77, 1'b0);
      slave_reply("t5_wait", 32'h77);
      check("t5_stray_after", 64'(stray_sync), 64'h1);

      // Reset three cycles into WAIT: everything clears, no response leaks out.
      @(negedge clk);
      set_req(2, 32'h88);
      ack_q.push_back('{idx: 2, data: 32'h88, err: 1'b0});
      wait_ack("t6_ack", a);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_outs", 64'({req_ack, rsp_valid, rsp_err, slv_out_sync, busy, stray_sync}), 64'h0);
      check("t6_rst_rsp_data", 64'(rsp_data), 64'h0);
      check("t6_rst_slv_out", 64'(slv_out), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_sync(32'hBEEF);
      check("t6_late_stray", 64'(stray_sync), 64'h1);
      set_req(1, 32'h91);
      set_req(0, 32'h90);
      push(0, 32'h90, 32'hC0, 1'b0);
      push(1, 32'h91, 32'hC1, 1'b0);
      slave_reply("t6_wait0", 32'hC0);
      slave_reply("t6_wait1", 32'hC1);

      repeat (5) @(negedge clk);
      check("end_ack_q", 64'(ack_q.size()), 64'h0);
      check("end_rsp_q", 64'(rsp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
